// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_forward_ctrl: execute-stage forwarding selects and load-use stall.
// Optional HAZARD_STATS_EN adds saturating stall / forward cycle counters.
// Revision: 1.0
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs_2,
    input  logic [REG_ADDR_W-1:0] rt_2,
    input  logic                  usesRs_2,
    input  logic                  usesRt_2,
    input  logic [REG_ADDR_W-1:0] dest_2,
    input  logic                  regWrite_2,
    input  logic                  memRead_2,
    input  logic                  flush,
    output logic [1:0]            frwdControl_1,
    output logic [1:0]            frwdControl_2,
    output logic                  stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stallCount,
    output logic [STAT_W-1:0]     fwdCount
`endif
);

    localparam logic [1:0] C_SEL_REG = 2'b00;
    localparam logic [1:0] C_SEL_EX  = 2'b01;
    localparam logic [1:0] C_SEL_WB  = 2'b10;

    // ID/EX
    logic [REG_ADDR_W-1:0] rs_3_q, rs_3_d, rt_3_q, rt_3_d, dest_3_q, dest_3_d;
    logic                  usesRs_3_q, usesRs_3_d, usesRt_3_q, usesRt_3_d;
    logic                  regWrite_3_q, regWrite_3_d, memRead_3_q, memRead_3_d;
    // EX/MEM
    logic [REG_ADDR_W-1:0] dest_4_q;
    logic                  regWrite_4_q, memRead_4_q;
    // MEM/WB
    logic [REG_ADDR_W-1:0] dest_5_q;
    logic                  regWrite_5_q;

    function automatic logic [1:0] fwd_sel(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  wr4,
        input logic [REG_ADDR_W-1:0] d4,
        input logic                  wr5,
        input logic [REG_ADDR_W-1:0] d5
    );
        // EX/MEM is checked first so the newest producer wins.
        if (uses && wr4 && (d4 != '0) && (d4 == src))
            return C_SEL_EX;
        else if (uses && wr5 && (d5 != '0) && (d5 == src))
            return C_SEL_WB;
        else
            return C_SEL_REG;
    endfunction

    always_comb begin
        frwdControl_1 = fwd_sel(usesRs_3_q, rs_3_q, regWrite_4_q, dest_4_q,
                                regWrite_5_q, dest_5_q);
        frwdControl_2 = fwd_sel(usesRt_3_q, rt_3_q, regWrite_4_q, dest_4_q,
                                regWrite_5_q, dest_5_q);
        stall = memRead_3_q && regWrite_3_q && (dest_3_q != '0) &&
                ((usesRs_2 && (rs_2 == dest_3_q)) ||
                 (usesRt_2 && (rt_2 == dest_3_q))) && !flush;
    end

    always_comb begin
        rs_3_d       = rs_2;
        rt_3_d       = rt_2;
        usesRs_3_d   = usesRs_2;
        usesRt_3_d   = usesRt_2;
        dest_3_d     = dest_2;
        regWrite_3_d = regWrite_2;
        memRead_3_d  = memRead_2;
        if (flush || stall) begin
            rs_3_d       = '0;
            rt_3_d       = '0;
            usesRs_3_d   = 1'b0;
            usesRt_3_d   = 1'b0;
            dest_3_d     = '0;
            regWrite_3_d = 1'b0;
            memRead_3_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_3_q       <= '0;
            rt_3_q       <= '0;
            usesRs_3_q   <= 1'b0;
            usesRt_3_q   <= 1'b0;
            dest_3_q     <= '0;
            regWrite_3_q <= 1'b0;
            memRead_3_q  <= 1'b0;
            dest_4_q     <= '0;
            regWrite_4_q <= 1'b0;
            memRead_4_q  <= 1'b0;
            dest_5_q     <= '0;
            regWrite_5_q <= 1'b0;
        end else begin
            rs_3_q       <= rs_3_d;
            rt_3_q       <= rt_3_d;
            usesRs_3_q   <= usesRs_3_d;
            usesRt_3_q   <= usesRt_3_d;
            dest_3_q     <= dest_3_d;
            regWrite_3_q <= regWrite_3_d;
            memRead_3_q  <= memRead_3_d;
            dest_4_q     <= dest_3_q;
            regWrite_4_q <= regWrite_3_q;
            memRead_4_q  <= memRead_3_q;
            dest_5_q     <= dest_4_q;
            regWrite_5_q <= regWrite_4_q;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_count_q, stall_count_d;
    logic [STAT_W-1:0] fwd_count_q, fwd_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        fwd_count_d   = fwd_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
        if (((frwdControl_1 != C_SEL_REG) || (frwdControl_2 != C_SEL_REG)) &&
            (fwd_count_q != '1))
            fwd_count_d = fwd_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign fwdCount   = fwd_count_q;
`endif

`ifndef SYNTHESIS
    // A load's data is not available in EX/MEM, so the stall must prevent this.
    a_no_ex_fwd_from_load : assert property (@(posedge clk) disable iff (reset)
        !(memRead_4_q && ((frwdControl_1 == C_SEL_EX) || (frwdControl_2 == C_SEL_EX))));
`endif

endmodule
`default_nettype wire
